param_seq_alu: RTL and testbench

Parametrised, registered successor to the 4-bit combinational SimpleALU. It has a WIDTH-bit datapath and valid/ready handshakes on the input and output sides. The add/sub/max/and/or/xor ops take one cycle; multiply is a multi-cycle shift-add. It sits between the operand-issue logic and the result consumer, and holds its result until the consumer accepts it.

---
 rtl/param_seq_alu.sv | 152 +++++++++++++++
 tb/tb_param_seq_alu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/param_seq_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/arith ops and a
// WIDTH-iteration shift-add multiply; the result is held until the consumer takes it.
module param_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       selection,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_hi,
  output logic             C_out,
  output logic             Zero,
  output logic             Err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     count;
  logic [WIDTH+1:0]     alu_out;
  logic                 alu_err, alu_cout;
  logic [WIDTH-1:0]     alu_res;

  // Packs {err, carry, result} for every single-cycle opcode.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       sel);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             err;
    sum  = '0;
    res  = '0;
    cout = 1'b0;
    err  = 1'b0;
    case (sel)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b};
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_SUB: begin
        // The carry out of a + ~b + 1 is exactly the no-borrow flag (a >= b).
        sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_MAX: begin
        cout = (a > b);
        res  = cout ? a : b;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ILL: err = 1'b1;
      default: ;
    endcase
    return {err, cout, res};
  endfunction

  assign accept   = in_valid && in_ready;
  assign mul_last = (count == CNT_W'(WIDTH-1));
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign alu_out  = alu_eval(A, B, selection);
  assign alu_err  = alu_out[WIDTH+1];
  assign alu_cout = alu_out[WIDTH];
  assign alu_res  = alu_out[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (selection == OP_MUL) ? MUL : DONE;
      MUL:  if (mul_last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Result    <= '0;
      Result_hi <= '0;
      C_out     <= 1'b0;
      Zero      <= 1'b0;
      Err       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (selection == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            count  <= '0;
          end else begin
            Result    <= alu_res;
            Result_hi <= '0;
            C_out     <= alu_cout;
            Zero      <= (alu_res == '0) && !alu_err;
            Err       <= alu_err;
          end
        end
        // One shift-add step per cycle; the last step publishes the product.
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (mul_last) begin
            Result    <= acc_nxt[WIDTH-1:0];
            Result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
            C_out     <= |acc_nxt[2*WIDTH-1:WIDTH];
            Zero      <= (acc_nxt == '0);
            Err       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed and randomized bench for param_seq_alu, checked against an arithmetic
// reference model of each opcode, including latency and handshake behaviour.
module tb_param_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [2:0]   selection;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result, Result_hi;
  logic         C_out, Zero, Err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  param_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .selection(selection), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Result_hi(Result_hi),
    .C_out(C_out), .Zero(Zero), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] sel,
                                output logic [W-1:0] r, output logic [W-1:0] rh,
                                output logic c, output logic z, output logic e);
    longint ua, ub, full, modv;
    ua = longint'(a);
    ub = longint'(b);
    modv = longint'(1) << W;
    r = '0; rh = '0; c = 1'b0; e = 1'b0; full = 0;
    case (sel)
      3'd0: begin full = ua + ub; r = W'(full % modv); c = (full >= modv); end
      3'd1: begin r = W'((ua - ub + modv) % modv); c = (ua >= ub); end
      3'd2: begin c = (ua > ub); r = c ? a : b; end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin full = ua * ub; r = W'(full % modv); rh = W'(full / modv); c = (rh != 0); end
      default: e = 1'b1;
    endcase
    z = (sel == 3'd6) ? (full == 0) : ((r == 0) && !e);
  endfunction

  // Entered just after a falling edge with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input int hold);
    logic [W-1:0] er, erh;
    logic ec, ez, ee;
    int lat, explat;
    model(a, b, sel, er, erh, ec, ez, ee);
    explat = (sel == 3'd6) ? W + 1 : 1;
    check({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; A = a; B = b; selection = sel;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0; A = W'($urandom); B = W'($urandom); selection = 3'($urandom);
    end while (!out_valid && lat < 40);
    check({tag, " latency"}, lat, explat);
    for (int k = 0; k <= hold; k++) begin
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " in_ready busy"}, in_ready, 0);
      check({tag, " Result"}, Result, er);
      check({tag, " Result_hi"}, Result_hi, erh);
      check({tag, " C_out"}, C_out, ec);
      check({tag, " Zero"}, Zero, ez);
      check({tag, " Err"}, Err, ee);
      if (k < hold) begin
        in_valid = 1'b1; A = W'($urandom); B = W'($urandom); selection = 3'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " handoff out_valid"}, out_valid, 0);
    check({tag, " handoff in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic saw_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; selection = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset outputs", {Result, Result_hi, C_out, Zero, Err}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add 200+100", 8'd200, 8'd100, 3'd0, 0);
    run_op("sub 5-7", 8'd5, 8'd7, 3'd1, 0);
    run_op("sub 7-5", 8'd7, 8'd5, 3'd1, 0);
    run_op("sub 9-9", 8'd9, 8'd9, 3'd1, 0);
    run_op("mul ff*ff", 8'hFF, 8'hFF, 3'd6, 0);
    run_op("mul 0*55", 8'h00, 8'h55, 3'd6, 1);
    run_op("add backpressure", 8'd1, 8'd1, 3'd0, 5);
    run_op("max", 8'h3C, 8'hA5, 3'd2, 0);
    run_op("max gt", 8'hA5, 8'h3C, 3'd2, 0);
    run_op("and", 8'h3C, 8'hA5, 3'd3, 0);
    run_op("or", 8'h3C, 8'hA5, 3'd4, 0);
    run_op("xor", 8'h3C, 8'hA5, 3'd5, 0);
    run_op("xor zero", 8'h5A, 8'h5A, 3'd5, 0);
    run_op("illegal", 8'h12, 8'h34, 3'd7, 0);
    run_op("mul backpressure", 8'd13, 8'd11, 3'd6, 3);

    // Abandon a multiply with reset four cycles after accept.
    in_valid = 1'b1; A = 8'hFF; B = 8'hFF; selection = 3'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid-mul in_ready", in_ready, 1);
    check("rst mid-mul out_valid", out_valid, 0);
    check("rst mid-mul outputs", {Result, Result_hi, C_out, Zero, Err}, 0);
    saw_valid = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst mid-mul no pulse", saw_valid, 0);
    run_op("add 3+4 after rst", 8'd3, 8'd4, 3'd0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op("random", W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
